ahb_rr_arbiter_3p: RTL and testbench
====================================

AHB_RR_ARBITER_3P -- requirements
Module: ahb_rr_arbiter_3p

Interface
REQ-001 The block SHALL have the port HCLK, input, 1 bit: AHB system clock; all state SHALL update on its rising edge.
REQ-002 The block SHALL have the port HRESETn, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have the ports req_port0, req_port1, req_port2, input, 1 bit each: input-stage request (held_tran & sel) for this output stage.
REQ-004 The block SHALL have the port HREADYM, input, 1 bit: muxed HREADY of the shared slave; 1 = address phase completes.
REQ-005 The block SHALL have the port HSELM, input, 1 bit: HSEL of the currently routed port.
REQ-006 The block SHALL have the port HTRANSM, input, 2 bits: HTRANS of the currently routed port (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-007 The block SHALL have the port HBURSTM, input, 3 bits: HBURST of the currently routed port.
REQ-008 The block SHALL have the port HMASTLOCKM, input, 1 bit: lock qualified by HSEL or an ongoing locked sequence.
REQ-009 The block SHALL have the port addr_in_port, output, 2 bits: granted port index (0..2), registered.
REQ-010 The block SHALL have the port no_port, output, 1 bit: 1 = no port routed, registered.

Function
REQ-011 Grant state (addr_in_port, no_port) SHALL update only on a rising HCLK edge with HREADYM=1; with HREADYM=0 all state SHALL hold.
REQ-012 The block SHALL keep a 4-bit beat counter beat_cnt.
REQ-013 With HREADYM=1, HSELM=1 and HTRANSM=NONSEQ, beat_cnt SHALL load 3 for HBURSTM=INCR4/WRAP4 (011/010), 7 for INCR8/WRAP8 (101/100), 15 for INCR16/WRAP16 (111/110), and 0 otherwise.
REQ-014 With HREADYM=1, HTRANSM=SEQ and beat_cnt!=0, beat_cnt SHALL decrement by 1.
REQ-015 With HREADYM=1 and HTRANSM=IDLE, beat_cnt SHALL clear to 0 (early burst termination).
REQ-016 hold SHALL assert when any of the following is true: HMASTLOCKM=1; HTRANSM=NONSEQ with a fixed-length burst; HTRANSM=SEQ with beat_cnt>1; HTRANSM=BUSY with beat_cnt!=0; HBURSTM=INCR (001) with HTRANSM in {SEQ, BUSY}.
REQ-017 With HREADYM=1 and hold=1, addr_in_port and no_port SHALL be unchanged, regardless of req_port* (the locked or burst owner keeps the slave even if its request drops).
REQ-018 With HREADYM=1 and hold=0, the block SHALL grant the first asserted request in round-robin order addr_in_port+1, addr_in_port+2, addr_in_port (mod 3), so the current owner has lowest priority.
REQ-019 When a port is granted under REQ-018, the block SHALL load addr_in_port with that index and clear no_port to 0.
REQ-020 With hold=0 and no request asserted, no_port SHALL go to 1 and addr_in_port SHALL retain the last grant, which remains the round-robin pointer.
REQ-021 Arbitration from no_port=1 SHALL use the retained addr_in_port as the pointer.
REQ-022 A new grant SHALL take effect for the address phase following the HREADYM=1 edge (one-cycle latency from request to addr_in_port).
REQ-023 addr_in_port SHALL never take the value 3; modulo-3 wrap SHALL be 2 -> 0.

Reset
REQ-024 While HRESETn=0, the block SHALL hold no_port=1, addr_in_port=2'b10 and beat_cnt=0, so port 0 has highest priority first.
REQ-025 Reset assertion mid-burst or mid-lock SHALL abort immediately; after release, arbitration SHALL restart per REQ-024.

Verification
REQ-026 The bench SHALL cover: after reset, req_port0..2=1, HTRANSM=IDLE, HREADYM=1 -> grants 0, 1, 2, 0 on successive edges with no_port=0.
REQ-027 The bench SHALL cover: port1 granted, INCR4 (NONSEQ then 3 SEQ) with req_port0=req_port2=1 -> addr_in_port=1 for all 4 beats; port 2 is granted on the edge completing the 3rd SEQ.
REQ-028 The bench SHALL cover: port0 granted, HMASTLOCKM=1 for 5 cycles with req_port0 dropped, req_port1=1 -> addr_in_port=0, no_port=0 throughout; port 1 is granted on the first HREADYM=1 edge with HMASTLOCKM=0.
REQ-029 The bench SHALL cover: HREADYM=0 for 3 cycles while only req_port2 toggles -> outputs unchanged until HREADYM=1.
REQ-030 The bench SHALL cover: WRAP8 on port2 terminated by IDLE after 2 SEQ -> beat_cnt=0, with the next edge granting port 0 if requested, else no_port=1 and addr_in_port=2.
REQ-031 The bench SHALL cover: HRESETn asserted during beat 3 of INCR16 -> immediately no_port=1, addr_in_port=2; after release with req_port1 only, port 1 is granted on the first HREADYM=1 edge.

Source files
------------

// File: rtl/ahb_rr_arbiter_3p.sv
// Round-robin address-phase arbiter for one AHB output stage shared by three input ports.
// Burst and lock tracking keep the current owner on the slave until the transfer sequence can be broken.
module ahb_rr_arbiter_3p (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       req_port0,
    input  logic       req_port1,
    input  logic       req_port2,
    input  logic       HREADYM,
    input  logic       HSELM,
    input  logic [1:0] HTRANSM,
    input  logic [2:0] HBURSTM,
    input  logic       HMASTLOCKM,
    output logic [1:0] addr_in_port,
    output logic       no_port
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;
    localparam logic [2:0] BURST_INCR   = 3'b001;

    logic [3:0] beat_cnt;
    logic [3:0] beat_load;
    logic [3:0] beat_next;
    logic       fixed_burst;
    logic       hold;
    logic [1:0] cand1;
    logic [1:0] cand2;
    logic       grant_valid;
    logic [1:0] grant_idx;

    function automatic logic req_of(input logic [1:0] idx, input logic r0,
                                    input logic r1, input logic r2);
        logic r;
        case (idx)
            2'd0:    r = r0;
            2'd1:    r = r1;
            2'd2:    r = r2;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    always_comb begin
        fixed_burst = HBURSTM[2] | HBURSTM[1];
        case (HBURSTM[2:1])
            2'b01:   beat_load = 4'd3;
            2'b10:   beat_load = 4'd7;
            2'b11:   beat_load = 4'd15;
            default: beat_load = 4'd0;
        endcase

        // Remaining-beat count describes the beats still to come after the current one.
        beat_next = beat_cnt;
        if (HSELM && (HTRANSM == TRANS_NONSEQ))
            beat_next = beat_load;
        else if ((HTRANSM == TRANS_SEQ) && (beat_cnt != 4'd0))
            beat_next = beat_cnt - 4'd1;
        else if (HTRANSM == TRANS_IDLE)
            beat_next = 4'd0;

        hold = HMASTLOCKM
            || ((HTRANSM == TRANS_NONSEQ) && fixed_burst)
            || ((HTRANSM == TRANS_SEQ) && (beat_cnt > 4'd1))
            || ((HTRANSM == TRANS_BUSY) && (beat_cnt != 4'd0))
            || ((HBURSTM == BURST_INCR)
                && ((HTRANSM == TRANS_SEQ) || (HTRANSM == TRANS_BUSY)));

        // Search order starts after the current owner, which comes last.
        cand1 = (addr_in_port == 2'd2) ? 2'd0 : addr_in_port + 2'd1;
        cand2 = (addr_in_port == 2'd0) ? 2'd2 : addr_in_port - 2'd1;

        grant_valid = 1'b1;
        grant_idx   = addr_in_port;
        if (req_of(cand1, req_port0, req_port1, req_port2))
            grant_idx = cand1;
        else if (req_of(cand2, req_port0, req_port1, req_port2))
            grant_idx = cand2;
        else if (req_of(addr_in_port, req_port0, req_port1, req_port2))
            grant_idx = addr_in_port;
        else
            grant_valid = 1'b0;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_in_port <= 2'd2;
            no_port      <= 1'b1;
            beat_cnt     <= 4'd0;
        end else if (HREADYM) begin
            beat_cnt <= beat_next;
            if (!hold) begin
                // With nobody requesting, the last grant stays as the pointer.
                if (grant_valid) begin
                    addr_in_port <= grant_idx;
                    no_port      <= 1'b0;
                end else begin
                    no_port <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_rr_arbiter_3p.sv
// Directed bench for ahb_rr_arbiter_3p: round-robin order, burst/lock hold, wait states and reset abort.
// Expected grant values are hand-derived for each step.
module tb_ahb_rr_arbiter_3p;

    logic       HCLK;
    logic       HRESETn;
    logic       req_port0;
    logic       req_port1;
    logic       req_port2;
    logic       HREADYM;
    logic       HSELM;
    logic [1:0] HTRANSM;
    logic [2:0] HBURSTM;
    logic       HMASTLOCKM;
    logic [1:0] addr_in_port;
    logic       no_port;

    int checks;
    int failures;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000;
    localparam logic [2:0] INCR   = 3'b001;
    localparam logic [2:0] INCR4  = 3'b011;
    localparam logic [2:0] WRAP8  = 3'b100;
    localparam logic [2:0] INCR16 = 3'b111;

    ahb_rr_arbiter_3p dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .req_port0    (req_port0),
        .req_port1    (req_port1),
        .req_port2    (req_port2),
        .HREADYM      (HREADYM),
        .HSELM        (HSELM),
        .HTRANSM      (HTRANSM),
        .HBURSTM      (HBURSTM),
        .HMASTLOCKM   (HMASTLOCKM),
        .addr_in_port (addr_in_port),
        .no_port      (no_port)
    );

    // Clock and reset
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Observed/expected are {no_port, addr_in_port}.
    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got no_port=%0b addr=%0d, expected no_port=%0b addr=%0d",
                     tag, got[2], got[1:0], exp[2], exp[1:0]);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic r0, input logic r1, input logic r2,
                         input logic [1:0] tr, input logic [2:0] bu, input logic lk);
        req_port0  = r0;
        req_port1  = r1;
        req_port2  = r2;
        HTRANSM    = tr;
        HBURSTM    = bu;
        HMASTLOCKM = lk;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        HRESETn  = 1'b0;
        HREADYM  = 1'b1;
        HSELM    = 1'b1;
        drive(1'b1, 1'b1, 1'b1, IDLE, SINGLE, 1'b0);
        step();
        step();
        check("reset_state", {no_port, addr_in_port}, 3'b1_10);
        HRESETn = 1'b1;

        // Round-robin with all ports requesting
        step(); check("rr_0", {no_port, addr_in_port}, 3'b0_00);
        step(); check("rr_1", {no_port, addr_in_port}, 3'b0_01);
        step(); check("rr_2", {no_port, addr_in_port}, 3'b0_10);
        step(); check("rr_wrap", {no_port, addr_in_port}, 3'b0_00);

        // INCR4 owned by port 1 while ports 0 and 2 wait
        drive(1'b0, 1'b1, 1'b0, IDLE, SINGLE, 1'b0);
        step(); check("incr4_own", {no_port, addr_in_port}, 3'b0_01);
        drive(1'b1, 1'b1, 1'b1, NONSEQ, INCR4, 1'b0);
        step(); check("incr4_nonseq", {no_port, addr_in_port}, 3'b0_01);
        HTRANSM = SEQ;
        step(); check("incr4_seq1", {no_port, addr_in_port}, 3'b0_01);
        step(); check("incr4_seq2", {no_port, addr_in_port}, 3'b0_01);
        step(); check("incr4_seq3", {no_port, addr_in_port}, 3'b0_10);

        // Lock held by port 0 after its request drops
        drive(1'b1, 1'b0, 1'b0, IDLE, SINGLE, 1'b0);
        step(); check("lock_own", {no_port, addr_in_port}, 3'b0_00);
        drive(1'b0, 1'b1, 1'b0, IDLE, SINGLE, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(); check($sformatf("lock_%0d", i), {no_port, addr_in_port}, 3'b0_00);
        end
        HMASTLOCKM = 1'b0;
        step(); check("lock_release", {no_port, addr_in_port}, 3'b0_01);

        // Wait states freeze the grant while req_port2 toggles
        drive(1'b0, 1'b0, 1'b1, IDLE, SINGLE, 1'b0);
        HREADYM = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_port2 = ~req_port2;
            step(); check($sformatf("wait_%0d", i), {no_port, addr_in_port}, 3'b0_01);
        end
        HREADYM   = 1'b1;
        req_port2 = 1'b1;
        step(); check("wait_release", {no_port, addr_in_port}, 3'b0_10);

        // WRAP8 on port 2 cut short by IDLE, port 0 waiting
        drive(1'b1, 1'b0, 1'b0, NONSEQ, WRAP8, 1'b0);
        step(); check("wrap8_nonseq", {no_port, addr_in_port}, 3'b0_10);
        HTRANSM = SEQ;
        step(); check("wrap8_seq1", {no_port, addr_in_port}, 3'b0_10);
        step(); check("wrap8_seq2", {no_port, addr_in_port}, 3'b0_10);
        HTRANSM = IDLE;
        step(); check("wrap8_idle_p0", {no_port, addr_in_port}, 3'b0_00);
        // A cleared count means BUSY on a fixed burst no longer holds
        drive(1'b0, 1'b1, 1'b0, BUSY, WRAP8, 1'b0);
        step(); check("wrap8_cnt_clear", {no_port, addr_in_port}, 3'b0_01);

        // Same termination with nobody waiting
        drive(1'b0, 1'b0, 1'b1, IDLE, SINGLE, 1'b0);
        step(); check("wrap8b_own", {no_port, addr_in_port}, 3'b0_10);
        drive(1'b0, 1'b0, 1'b0, NONSEQ, WRAP8, 1'b0);
        step(); check("wrap8b_nonseq", {no_port, addr_in_port}, 3'b0_10);
        HTRANSM = SEQ;
        step(); step();
        HTRANSM = IDLE;
        step(); check("wrap8b_idle_none", {no_port, addr_in_port}, 3'b1_10);
        drive(1'b0, 1'b1, 1'b0, IDLE, SINGLE, 1'b0);
        step(); check("from_no_port", {no_port, addr_in_port}, 3'b0_01);

        // Undefined-length INCR holds only through SEQ/BUSY
        drive(1'b0, 1'b1, 1'b0, NONSEQ, INCR, 1'b0);
        step(); check("incr_nonseq", {no_port, addr_in_port}, 3'b0_01);
        drive(1'b1, 1'b1, 1'b1, SEQ, INCR, 1'b0);
        step(); check("incr_seq", {no_port, addr_in_port}, 3'b0_01);
        HTRANSM = BUSY;
        step(); check("incr_busy", {no_port, addr_in_port}, 3'b0_01);
        HTRANSM = IDLE;
        step(); check("incr_idle", {no_port, addr_in_port}, 3'b0_10);

        // Reset during beat 3 of INCR16
        drive(1'b1, 1'b0, 1'b0, IDLE, SINGLE, 1'b0);
        step(); check("incr16_own", {no_port, addr_in_port}, 3'b0_00);
        drive(1'b1, 1'b1, 1'b1, NONSEQ, INCR16, 1'b0);
        step(); check("incr16_nonseq", {no_port, addr_in_port}, 3'b0_00);
        HTRANSM = SEQ;
        step(); step();
        check("incr16_beat3", {no_port, addr_in_port}, 3'b0_00);
        #2 HRESETn = 1'b0;
        #1 check("reset_async", {no_port, addr_in_port}, 3'b1_10);
        step(); check("reset_held", {no_port, addr_in_port}, 3'b1_10);
        HRESETn = 1'b1;
        // SEQ on INCR16 must not hold once the count has been reset
        drive(1'b0, 1'b1, 1'b0, SEQ, INCR16, 1'b0);
        HREADYM = 1'b0;
        step(); check("post_reset_wait", {no_port, addr_in_port}, 3'b1_10);
        HREADYM = 1'b1;
        step(); check("post_reset_grant", {no_port, addr_in_port}, 3'b0_01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
